// File: rtl/adder_tree_reduce.sv
// Lane-product reduction: registers a LENGTH-lane product word, sums the lanes
// through a pipelined binary adder tree, and accumulates the per-beat sums over
// a frame delimited by in_last. One dot-product result per frame leaves on a
// valid/ready handshake; a held result stalls the whole pipeline.
module adder_tree_reduce #(
   parameter int LENGTH = 16,
   parameter int INT16  = 16,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LENGTH*INT16-1:0] in_muls,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [ACC_W-1:0]        out_sum,
   output logic [CNT_W-1:0]        out_beats,
   output logic                    out_ovf,
   output logic                    out_valid,
   input  logic                    out_ready
);

   // Tree level widths grow by one bit per level so no sum is ever truncated.
   localparam int W1 = INT16 + 1;
   localparam int W2 = INT16 + 2;
   localparam int W3 = INT16 + 3;
   localparam int W4 = INT16 + 4;

   logic                    adv;

   // Stage 0 is the input capture register; stages 1..4 are the tree levels.
   logic [LENGTH*INT16-1:0] s0_data_q, s0_data_d;
   logic [4:0]              stg_valid_q, stg_valid_d;
   logic [4:0]              stg_last_q, stg_last_d;

   logic [INT16-1:0]        lane [LENGTH];
   logic [W1-1:0]           s1_q [LENGTH/2];
   logic [W1-1:0]           s1_d [LENGTH/2];
   logic [W2-1:0]           s2_q [LENGTH/4];
   logic [W2-1:0]           s2_d [LENGTH/4];
   logic [W3-1:0]           s3_q [LENGTH/8];
   logic [W3-1:0]           s3_d [LENGTH/8];
   logic [W4-1:0]           s4_q, s4_d;

   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic [ACC_W-1:0]        out_sum_q, out_sum_d;
   logic [CNT_W-1:0]        out_beats_q, out_beats_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic [ACC_W:0]          sum_full;
   logic [CNT_W-1:0]        cnt_next;

   // The pipeline only moves when no result is waiting on a stalled consumer.
   assign adv      = !(out_valid_q && !out_ready);
   assign in_ready = adv;

   genvar gi;
   generate
      for (gi = 0; gi < LENGTH; gi++) begin : g_lane
         assign lane[gi] = s0_data_q[gi*INT16 +: INT16];
      end
   endgenerate

   // Input capture plus valid/last shift register travelling beside the tree data.
   always_comb begin
      s0_data_d   = s0_data_q;
      stg_valid_d = stg_valid_q;
      stg_last_d  = stg_last_q;
      if (adv) begin
         s0_data_d   = in_muls;
         stg_valid_d = {stg_valid_q[3:0], in_valid};
         // in_last means nothing without in_valid, so mask it on entry.
         stg_last_d  = {stg_last_q[3:0], in_valid && in_last};
      end
   end

   // Adder tree levels: pairwise zero-extended sums, held while stalled.
   always_comb begin
      for (int i = 0; i < LENGTH/2; i++) begin
         s1_d[i] = adv ? (W1'(lane[2*i]) + W1'(lane[2*i+1])) : s1_q[i];
      end
      for (int i = 0; i < LENGTH/4; i++) begin
         s2_d[i] = adv ? (W2'(s1_q[2*i]) + W2'(s1_q[2*i+1])) : s2_q[i];
      end
      for (int i = 0; i < LENGTH/8; i++) begin
         s3_d[i] = adv ? (W3'(s2_q[2*i]) + W3'(s2_q[2*i+1])) : s3_q[i];
      end
      s4_d = adv ? (W4'(s3_q[0]) + W4'(s3_q[1])) : s4_q;
   end

   assign sum_full = {1'b0, acc_q} + (ACC_W+1)'(s4_q);
   assign cnt_next = cnt_q + CNT_W'(1);

   // Accumulate beats; on the last beat publish the result and restart the frame.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_beats_d = out_beats_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q && !out_ready;
      if (adv && stg_valid_q[4]) begin
         if (!stg_last_q[4]) begin
            acc_d = sum_full[ACC_W-1:0];
            cnt_d = cnt_next;
            ovf_d = ovf_q | sum_full[ACC_W];
         end else begin
            out_sum_d   = sum_full[ACC_W-1:0];
            out_beats_d = cnt_next;
            out_ovf_d   = ovf_q | sum_full[ACC_W];
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
         end
      end
   end

   // State registers; reset discards any partial frame or pending result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_data_q   <= '0;
         stg_valid_q <= '0;
         stg_last_q  <= '0;
         for (int i = 0; i < LENGTH/2; i++) s1_q[i] <= '0;
         for (int i = 0; i < LENGTH/4; i++) s2_q[i] <= '0;
         for (int i = 0; i < LENGTH/8; i++) s3_q[i] <= '0;
         s4_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_beats_q <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s0_data_q   <= s0_data_d;
         stg_valid_q <= stg_valid_d;
         stg_last_q  <= stg_last_d;
         for (int i = 0; i < LENGTH/2; i++) s1_q[i] <= s1_d[i];
         for (int i = 0; i < LENGTH/4; i++) s2_q[i] <= s2_d[i];
         for (int i = 0; i < LENGTH/8; i++) s3_q[i] <= s3_d[i];
         s4_q        <= s4_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_sum_q   <= out_sum_d;
         out_beats_q <= out_beats_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_sum   = out_sum_q;
   assign out_beats = out_beats_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_reduce.sv
// Directed bench for adder_tree_reduce: each task drives one scenario and
// compares outputs against hand-computed values, one line per transaction.
module tb_adder_tree_reduce;

   localparam int LENGTH = 16;
   localparam int INT16  = 16;
   localparam int ACC_W  = 32;
   localparam int CNT_W  = 16;
   localparam int BOUND  = 200;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [LENGTH*INT16-1:0] in_muls;
   logic                    in_valid;
   logic                    in_last;
   logic                    in_ready;
   logic [ACC_W-1:0]        out_sum;
   logic [CNT_W-1:0]        out_beats;
   logic                    out_ovf;
   logic                    out_valid;
   logic                    out_ready;

   int checks = 0;
   int errors = 0;

   adder_tree_reduce #(
      .LENGTH(LENGTH), .INT16(INT16), .ACC_W(ACC_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .in_muls(in_muls), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
      .out_beats(out_beats), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [LENGTH*INT16-1:0] fill(input logic [INT16-1:0] v);
      logic [LENGTH*INT16-1:0] r;
      for (int i = 0; i < LENGTH; i++) r[i*INT16 +: INT16] = v;
      return r;
   endfunction

   // Present one beat for one edge; inputs change 1 time unit after the edge.
   task automatic drive_beat(input logic [LENGTH*INT16-1:0] d, input logic last);
      in_muls  = d;
      in_valid = 1'b1;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait for out_valid; the caller checks out_valid afterwards.
   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < BOUND) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; in_muls = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      idle(3);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", out_valid); end
      checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", out_sum); end
      checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL reset_beats got %0d want 0", out_beats); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d want 0", out_ovf); end
      reset = 1'b1;
      idle(1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d want 1", in_ready); end
      $display("reset: out_valid=%0d out_sum=%0d in_ready=%0d", out_valid, out_sum, in_ready);
   endtask

   task automatic test_single_beat();
      int cyc;
      drive_beat(fill(16'h0001), 1'b1);
      wait_out(cyc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d want 1", out_valid); end
      checks++; if (cyc != 5) begin errors++; $display("FAIL single_latency got %0d want 5", cyc); end
      checks++; if (out_sum !== 32'd16) begin errors++; $display("FAIL single_sum got %0d want 16", out_sum); end
      checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL single_beats got %0d want 1", out_beats); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %0d want 0", out_ovf); end
      $display("single: sum=%0d beats=%0d ovf=%0d latency=%0d", out_sum, out_beats, out_ovf, cyc);
      idle(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0d want 0", out_valid); end
   endtask

   task automatic test_three_beat();
      logic [LENGTH*INT16-1:0] b1, b2;
      int cyc;
      for (int i = 0; i < LENGTH; i++) begin
         b1[i*INT16 +: INT16] = 16'(i);
         b2[i*INT16 +: INT16] = 16'(i*2);
      end
      drive_beat(b1, 1'b0);
      drive_beat(b2, 1'b0);
      drive_beat(fill(16'hFFFF), 1'b1);
      wait_out(cyc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL three_valid got %0d want 1", out_valid); end
      checks++; if (out_sum !== 32'd1048920) begin errors++; $display("FAIL three_sum got %0d want 1048920", out_sum); end
      checks++; if (out_beats !== 16'd3) begin errors++; $display("FAIL three_beats got %0d want 3", out_beats); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL three_ovf got %0d want 0", out_ovf); end
      $display("three: sum=%0d beats=%0d ovf=%0d", out_sum, out_beats, out_ovf);
      idle(2);
   endtask

   task automatic test_overflow();
      int cyc;
      for (int b = 0; b < 4097; b++) drive_beat(fill(16'hFFFF), b == 4096);
      wait_out(cyc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0d want 1", out_valid); end
      checks++; if (out_sum !== 32'd983024) begin errors++; $display("FAIL ovf_sum got %0d want 983024", out_sum); end
      checks++; if (out_beats !== 16'd4097) begin errors++; $display("FAIL ovf_beats got %0d want 4097", out_beats); end
      checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d want 1", out_ovf); end
      $display("overflow: sum=%0d beats=%0d ovf=%0d", out_sum, out_beats, out_ovf);
      idle(1);
      drive_beat(fill(16'h0001), 1'b1);
      wait_out(cyc);
      checks++; if (out_sum !== 32'd16) begin errors++; $display("FAIL ovf_next_sum got %0d want 16", out_sum); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %0d want 0", out_ovf); end
      checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL ovf_next_beats got %0d want 1", out_beats); end
      $display("after overflow: sum=%0d beats=%0d ovf=%0d", out_sum, out_beats, out_ovf);
      idle(2);
   endtask

   task automatic test_back_to_back();
      int cyc;
      drive_beat(fill(16'h0001), 1'b1);
      drive_beat(fill(16'h0002), 1'b1);
      wait_out(cyc);
      checks++; if (out_sum !== 32'd16) begin errors++; $display("FAIL b2b_first got %0d want 16", out_sum); end
      idle(1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %0d want 1", out_valid); end
      checks++; if (out_sum !== 32'd32) begin errors++; $display("FAIL b2b_second_sum got %0d want 32", out_sum); end
      $display("back_to_back: second sum=%0d valid=%0d", out_sum, out_valid);
      idle(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %0d want 0", out_valid); end
      idle(1);
   endtask

   task automatic test_backpressure();
      int cyc;
      out_ready = 1'b0;
      drive_beat(fill(16'h0001), 1'b1);
      drive_beat(fill(16'h0002), 1'b1);
      wait_out(cyc);
      for (int s = 0; s < 3; s++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %0d want 1", s, out_valid); end
         checks++; if (out_sum !== 32'd16) begin errors++; $display("FAIL bp_hold_sum[%0d] got %0d want 16", s, out_sum); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0d want 0", s, in_ready); end
         $display("stall %0d: sum=%0d in_ready=%0d", s, out_sum, in_ready);
         idle(1);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0d want 1", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %0d want 1", out_valid); end
      checks++; if (out_sum !== 32'd32) begin errors++; $display("FAIL bp_second_sum got %0d want 32", out_sum); end
      $display("after stall: sum=%0d valid=%0d", out_sum, out_valid);
      idle(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0d want 0", out_valid); end
   endtask

   task automatic test_gaps();
      int cyc;
      drive_beat(fill(16'h0001), 1'b0);
      idle(4);
      drive_beat(fill(16'h0001), 1'b1);
      wait_out(cyc);
      checks++; if (out_sum !== 32'd32) begin errors++; $display("FAIL gaps_sum got %0d want 32", out_sum); end
      checks++; if (out_beats !== 16'd2) begin errors++; $display("FAIL gaps_beats got %0d want 2", out_beats); end
      $display("gaps: sum=%0d beats=%0d", out_sum, out_beats);
      idle(2);
   endtask

   task automatic test_reset_mid_frame();
      int cyc;
      int extra;
      drive_beat(fill(16'h0001), 1'b0);
      drive_beat(fill(16'h0001), 1'b0);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      idle(1);
      drive_beat(fill(16'h0001), 1'b1);
      wait_out(cyc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_reset_valid got %0d want 1", out_valid); end
      checks++; if (out_sum !== 32'd16) begin errors++; $display("FAIL mid_reset_sum got %0d want 16", out_sum); end
      checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL mid_reset_beats got %0d want 1", out_beats); end
      $display("mid_reset: sum=%0d beats=%0d", out_sum, out_beats);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL mid_reset_extra got %0d want 0", extra); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_three_beat();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_gaps();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_tree_reduce.md
Name: adder_tree_reduce

Overview:
- Consumer end of the lane-multiplier stage. Takes the registered 16-lane product word (LENGTH lanes × INT16 bits).
- Reduces the 16 lanes through a 4-level pipelined adder tree and accumulates the per-beat sums across a multi-beat frame delimited by in_last.
- Returns one dot-product result per frame over a valid/ready output handshake, with stall back-pressure to the producer.

Parameters:
- LENGTH, 16, number of product lanes; fixed power of two, tree depth = log2(LENGTH) = 4.
- INT16, 16, bit width of each lane product, unsigned.
- ACC_W, 32, accumulator/result width; must be ≥ INT16+4.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_muls  in  LENGTH*INT16  packed lane products; lane i = bits [16i+15:16i].
- in_valid  in  1  in_muls is valid this cycle.
- in_last  in  1  qualifies in_valid; final beat of the frame.
- in_ready  out  1  block accepts a beat this cycle.
- out_sum  out  ACC_W  frame dot-product result.
- out_beats  out  CNT_W  number of beats in the frame.
- out_ovf  out  1  accumulator wrapped during the frame (sticky per frame).
- out_valid  out  1  out_sum/out_beats/out_ovf valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline data and valid bits cleared, accumulator=0, beat counter=0, overflow flag=0, out_sum=0, out_beats=0, out_ovf=0, out_valid=0. in_ready=1 after reset release.
- Stall: adv = !(out_valid && !out_ready). in_ready = adv. While adv=0, every stage register holds. A beat is accepted only when in_valid && in_ready.
- Adder pipeline stages, all unsigned with zero extension and no truncation inside the tree:
  - S1: 8 pair sums, 17b.
  - S2: 4 sums, 18b.
  - S3: 2 sums, 19b.
  - S4: 1 sum, 20b.
  - Each stage carries valid and last bits alongside its data.
- S5, accumulate/output, acts on S4 valid when adv=1:
  - sum = acc + zext(S4). ovf_next = ovf | carry-out of that add. Arithmetic wraps modulo 2^ACC_W.
  - cnt_next = cnt + 1, wrapping.
  - If S4.last=0: acc ← sum, ovf ← ovf_next, cnt ← cnt_next.
  - If S4.last=1: out_sum ← sum, out_beats ← cnt_next, out_ovf ← ovf_next, out_valid ← 1. Then acc, cnt and ovf clear to 0 in the same edge, so the next frame starts clean with no bubble.
- Output handshake:
  - out_valid falls on the edge where out_ready=1, unless a new last beat reaches S5 at that same edge; in that case out_valid stays 1 with the new data.
  - Output fields are stable while out_valid && !out_ready.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+5 with no stall. Throughput is 1 beat/cycle. Back-to-back single-beat frames give out_valid on consecutive cycles when out_ready=1.
- in_last is ignored when in_valid=0. A frame of one beat is legal: out_beats=1.
- Gaps (in_valid=0) inside a frame are legal; bubbles propagate and do not touch acc or cnt.
- Reset asserted mid-frame or with out_valid pending: all state is discarded immediately. The partial frame is lost and no result is emitted for it.

Test Plan:
- Single beat, all lanes 0x0001, in_last=1, out_ready=1 -> out_valid 5 cycles later; out_sum=16, out_beats=1, out_ovf=0.
- 3-beat frame, lane i = i (beat 1), i*2 (beat 2), 0xFFFF (beat 3) -> out_sum = 120+240+1048560 = 1048920, out_beats=3.
- Overflow: 4097 beats, all lanes 0xFFFF -> out_sum=983024, out_ovf=1, out_beats=4097. The next 1-beat frame of 1s gives out_sum=16, out_ovf=0.
- Back-pressure: two 1-beat frames (results 16 and 32), out_ready held low 3 cycles after the first out_valid:
  - out_sum=16 stable during the stall; in_ready=0 during the stall.
  - The second result follows on the cycle after out_ready=1, with no loss or duplication.
- Gaps: 2-beat frame with 4 idle cycles between beats (lanes all 1) -> out_sum=32, out_beats=2.
- Reset mid-frame: 2 beats sent without last, reset pulsed low 1 cycle, then a 1-beat frame of 1s -> only one result, out_sum=16, out_beats=1.
